// File: rtl/wb_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe_pkg
//  Shared constants for the writeback stage of the RV32 core:
//   - reg_src select codes (where the register write data comes from)
//   - load funct3 codes
//   - writeback FSM state encoding
//  Imported by wb_stage_pipe and wb_load_ext.
// -----------------------------------------------------------------------------
package wb_stage_pipe_pkg;

   // Write-data source selects carried down the pipe with each instruction
   localparam logic [1:0] FROM_ALU = 2'd0;
   localparam logic [1:0] FROM_MEM = 2'd1;
   localparam logic [1:0] FROM_IMM = 2'd2;
   localparam logic [1:0] FROM_PC  = 2'd3;

   // Load funct3 codes (RV32I)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // IDLE  : entry empty or about to retire
   // WAIT  : a load is held and its response has not arrived yet
   // DRAIN : the held load was flushed, its response must still be swallowed
   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_WAIT  = 2'd1,
      WB_DRAIN = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// -----------------------------------------------------------------------------
// wb_load_ext
//  Purely combinational sub-word load extraction for the writeback stage.
//  Ports:
//   funct3  in   3     load type (LB/LH/LW/LBU/LHU)
//   offset  in   2     byte offset within the word (load address bits [1:0])
//   word    in   XLEN  aligned word returned by data memory
//   value   out  XLEN  extracted and sign/zero-extended load value
// -----------------------------------------------------------------------------
module wb_load_ext
   import wb_stage_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half out of the aligned word, then extend
   // according to the load type. Halfword loads only look at offset[1], so a
   // misaligned LH simply reads the half containing the addressed byte. Any
   // funct3 that is not a sub-word load passes the whole word through.
   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase

      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   value = word;
         default: value = word;
      endcase
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
//  Registered writeback stage between the MEM/WB boundary and the register
//  file. Holds one instruction, selects its write data (ALU, memory, immediate
//  or PC+4), extends sub-word loads and stalls while a load response is late.
//
//  Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           MEM-stage handshake (transfer also needs !flush)
//   in_reg_src, in_reg_we, in_rd  write source, write enable, destination
//   in_funct3                     load type
//   in_alu_result                 ALU result / load address
//   in_imm, in_pc_plus4           immediate and PC+4 candidates
//   mem_rsp_valid, mem_rsp_data   data-memory read response
//   flush                         kill held entry, block acceptance
//   rf_we, rf_waddr, rf_wdata     register-file write port
//   load_pending                  held load still waiting (to hazard unit)
//   instret [63:0]                retired-instruction counter (WB_INSTRET_EN only)
//
//  Configuration macro: WB_INSTRET_EN adds the instret counter and port.
// -----------------------------------------------------------------------------
module wb_stage_pipe
   import wb_stage_pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int REG_SRC_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_SRC_W-1:0]  in_reg_src,
   input  logic                  in_reg_we,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic [XLEN-1:0]       in_imm,
   input  logic [XLEN-1:0]       in_pc_plus4,
   input  logic                  mem_rsp_valid,
   input  logic [XLEN-1:0]       mem_rsp_data,
   input  logic                  flush,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  load_pending
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]           instret
`endif
);

   wb_state_t             state;

   logic                  e_valid;
   logic [REG_SRC_W-1:0]  e_reg_src;
   logic                  e_reg_we;
   logic [REG_ADDR_W-1:0] e_rd;
   logic [2:0]            e_funct3;
   logic [XLEN-1:0]       e_alu_result;
   logic [XLEN-1:0]       e_imm;
   logic [XLEN-1:0]       e_pc_plus4;

   logic                  e_is_load;
   logic                  retire;
   logic                  transfer;
   logic [XLEN-1:0]       load_value;
   logic [XLEN-1:0]       wb_data;

   // Handshake and retire decisions. Flush wins over a retire in the same
   // cycle, so a flushed entry never writes and never counts as retired. In
   // DRAIN the entry is already empty but a dead response is still owed, so
   // new work is held off until it has been swallowed.
   always_comb begin
      e_is_load    = e_valid && (e_reg_src == FROM_MEM);
      retire       = e_valid && !flush && (!e_is_load || mem_rsp_valid);
      in_ready     = (state != WB_DRAIN) && (!e_valid || retire);
      transfer     = in_valid && in_ready && !flush;
      load_pending = e_is_load && !mem_rsp_valid;
   end

   // Single-entry holding register. Flush clears it, a transfer refills it
   // (even in the cycle the previous entry retires), otherwise a retiring
   // entry is dropped. Clearing rd on reset keeps rf_waddr at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_valid      <= 1'b0;
         e_reg_src    <= '0;
         e_reg_we     <= 1'b0;
         e_rd         <= '0;
         e_funct3     <= '0;
         e_alu_result <= '0;
         e_imm        <= '0;
         e_pc_plus4   <= '0;
      end else if (flush) begin
         e_valid      <= 1'b0;
      end else if (transfer) begin
         e_valid      <= 1'b1;
         e_reg_src    <= in_reg_src;
         e_reg_we     <= in_reg_we;
         e_rd         <= in_rd;
         e_funct3     <= in_funct3;
         e_alu_result <= in_alu_result;
         e_imm        <= in_imm;
         e_pc_plus4   <= in_pc_plus4;
      end else if (retire) begin
         e_valid      <= 1'b0;
      end
   end

   // Load-tracking FSM. WAIT follows any held load that is still missing its
   // response. A flush while a load is outstanding moves to DRAIN so that the
   // one response memory still owes us is discarded instead of being written
   // for the next load. A flush in the same cycle the response arrives has
   // nothing left to drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WB_IDLE;
      end else begin
         case (state)
            WB_DRAIN: begin
               if (mem_rsp_valid) begin
                  state <= WB_IDLE;
               end
            end
            default: begin
               if (flush && load_pending) begin
                  state <= WB_DRAIN;
               end else if (load_pending) begin
                  state <= WB_WAIT;
               end else begin
                  state <= WB_IDLE;
               end
            end
         endcase
      end
   end

   wb_load_ext #(
      .XLEN   (XLEN)
   ) u_load_ext (
      .funct3 (e_funct3),
      .offset (e_alu_result[1:0]),
      .word   (mem_rsp_data),
      .value  (load_value)
   );

   // Write-data select. An empty entry drives zero so the register-file port
   // never shows stale data; the write enable masks x0.
   always_comb begin
      wb_data = '0;
      if (e_valid) begin
         case (e_reg_src)
            FROM_ALU: wb_data = e_alu_result;
            FROM_MEM: wb_data = load_value;
            FROM_IMM: wb_data = e_imm;
            FROM_PC:  wb_data = e_pc_plus4;
            default:  wb_data = '0;
         endcase
      end
      rf_we    = retire && e_reg_we && (e_rd != '0);
      rf_waddr = e_rd;
      rf_wdata = wb_data;
   end

`ifdef WB_INSTRET_EN
   // Retired-instruction counter. Every retire counts, including x0 targets
   // and non-writing instructions; flushed entries and drained responses do
   // not. Wraps naturally at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret <= 64'd0;
      end else if (retire) begin
         instret <= instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_pipe
//  Directed testbench for wb_stage_pipe with a behavioural model of the
//  writeback stage and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_wb_stage_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_reg_src;
   logic        in_reg_we;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result;
   logic [31:0] in_imm;
   logic [31:0] in_pc_plus4;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        load_pending;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
`endif

   int checks = 0;
   int errors = 0;

   wb_stage_pipe #(
      .XLEN          (32),
      .REG_ADDR_W    (5),
      .REG_SRC_W     (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_reg_src    (in_reg_src),
      .in_reg_we     (in_reg_we),
      .in_rd         (in_rd),
      .in_funct3     (in_funct3),
      .in_alu_result (in_alu_result),
      .in_imm        (in_imm),
      .in_pc_plus4   (in_pc_plus4),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .flush         (flush),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .load_pending  (load_pending)
`ifdef WB_INSTRET_EN
      ,
      .instret       (instret)
`endif
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the held instruction
   typedef struct {
      bit        valid;
      bit [1:0]  src;
      bit        we;
      bit [4:0]  rd;
      bit [2:0]  f3;
      bit [31:0] alu;
      bit [31:0] imm;
      bit [31:0] pc4;
   } instr_t;

   instr_t          held;
   bit              draining = 1'b0;
   longint unsigned m_instret = 0;
   bit              model_live = 1'b0;

   // Load extraction by shifting and masking, then sign fix-up by arithmetic
   function automatic bit [31:0] load_result(bit [2:0] f3, bit [1:0] off, bit [31:0] w);
      bit [31:0] b;
      bit [31:0] h;
      b = (w >> (8 * off)) & 32'h0000_00FF;
      h = (w >> (16 * off[1])) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic bit [31:0] value_of(instr_t e, bit [31:0] rsp);
      case (e.src)
         2'd0:    return e.alu;
         2'd1:    return load_result(e.f3, e.alu[1:0], rsp);
         2'd2:    return e.imm;
         default: return e.pc4;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle the stage is out of reset, the DUT
   // outputs must equal what the model says the held instruction produces.
   bit        c_is_load, c_done, c_ready, c_we;
   bit [31:0] c_wdata;
   always @(negedge clk) begin
      if (model_live && !rst) begin
         c_is_load = held.valid && (held.src == 2'd1);
         c_done    = held.valid && !flush && (!c_is_load || mem_rsp_valid);
         c_ready   = !draining && (!held.valid || c_done);
         c_we      = c_done && held.we && (held.rd != 5'd0);
         c_wdata   = held.valid ? value_of(held, mem_rsp_data) : 32'd0;
         checkOutput("cmp_in_ready", in_ready, c_ready);
         checkOutput("cmp_rf_we", rf_we, c_we);
         checkOutput("cmp_rf_waddr", rf_waddr, held.rd);
         checkOutput("cmp_rf_wdata", rf_wdata, c_wdata);
         checkOutput("cmp_load_pending", load_pending, c_is_load && !mem_rsp_valid);
`ifdef WB_INSTRET_EN
         checkOutput("cmp_instret", instret, m_instret);
`endif
      end
   end

   // Model state update on each rising edge
   bit m_is_load, m_done, m_ready;
   always @(posedge clk) begin
      if (rst) begin
         held       = '{default: 0};
         draining   = 1'b0;
         m_instret  = 0;
         model_live = 1'b1;
      end else if (model_live) begin
         m_is_load = held.valid && (held.src == 2'd1);
         m_done    = held.valid && !flush && (!m_is_load || mem_rsp_valid);
         m_ready   = !draining && (!held.valid || m_done);
         if (m_done) m_instret = m_instret + 1;
         if (draining) begin
            if (mem_rsp_valid) draining = 1'b0;
         end else if (flush && m_is_load && !mem_rsp_valid) begin
            draining = 1'b1;
         end
         if (flush) begin
            held.valid = 1'b0;
         end else if (in_valid && m_ready) begin
            held = '{1'b1, in_reg_src, in_reg_we, in_rd, in_funct3,
                     in_alu_result, in_imm, in_pc_plus4};
         end else if (m_done) begin
            held.valid = 1'b0;
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge
   task automatic applyStimulus(input bit v, input bit [1:0] src, input bit we,
                                input bit [4:0] rd, input bit [2:0] f3,
                                input bit [31:0] alu, input bit [31:0] imm,
                                input bit [31:0] pc4, input bit rv,
                                input bit [31:0] rdata, input bit fl);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      in_valid      = v;
      in_reg_src    = src;
      in_reg_we     = we;
      in_rd         = rd;
      in_funct3     = f3;
      in_alu_result = alu;
      in_imm        = imm;
      in_pc_plus4   = pc4;
      mem_rsp_valid = rv;
      mem_rsp_data  = rdata;
      flush         = fl;
      #1;
   endtask

   task automatic idleCycle(input bit rv, input bit [31:0] rdata, input bit fl);
      applyStimulus(1'b0, 2'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, rv, rdata, fl);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_rf_we"}, rf_we, 1'b0);
      checkOutput({tag, "_rf_waddr"}, rf_waddr, 5'd0);
      checkOutput({tag, "_rf_wdata"}, rf_wdata, 32'd0);
      checkOutput({tag, "_load_pending"}, load_pending, 1'b0);
      checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
`ifdef WB_INSTRET_EN
      checkOutput({tag, "_instret"}, instret, 64'd0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_reg_src = 0; in_reg_we = 0; in_rd = 0; in_funct3 = 0;
      in_alu_result = 0; in_imm = 0; in_pc_plus4 = 0;
      mem_rsp_valid = 0; mem_rsp_data = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");

      // ALU write, one cycle after transfer
      applyStimulus(1, 2'd0, 1, 5'd5, 3'd0, 32'h1234, 0, 0, 0, 0, 0);
      checkOutput("alu_accept", in_ready, 1'b1);
      idleCycle(0, 0, 0);
      checkOutput("alu_we", rf_we, 1'b1);
      checkOutput("alu_waddr", rf_waddr, 5'd5);
      checkOutput("alu_wdata", rf_wdata, 32'h1234);

      // Back-to-back IMM then PC+4
      applyStimulus(1, 2'd2, 1, 5'd1, 3'd0, 0, 32'd7, 0, 0, 0, 0);
      applyStimulus(1, 2'd3, 1, 5'd2, 3'd0, 0, 0, 32'h104, 0, 0, 0);
      checkOutput("imm_ready", in_ready, 1'b1);
      checkOutput("imm_we", rf_we, 1'b1);
      checkOutput("imm_waddr", rf_waddr, 5'd1);
      checkOutput("imm_wdata", rf_wdata, 32'd7);
      idleCycle(0, 0, 0);
      checkOutput("pc_we", rf_we, 1'b1);
      checkOutput("pc_waddr", rf_waddr, 5'd2);
      checkOutput("pc_wdata", rf_wdata, 32'h104);

      // LB offset 2, response three cycles late
      applyStimulus(1, 2'd1, 1, 5'd3, 3'b000, 32'h1002, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      checkOutput("lb_pending1", load_pending, 1'b1);
      checkOutput("lb_stall1", in_ready, 1'b0);
      idleCycle(0, 0, 0);
      checkOutput("lb_pending2", load_pending, 1'b1);
      checkOutput("lb_nowrite", rf_we, 1'b0);
      idleCycle(1, 32'h0080FF00, 0);
      checkOutput("lb_we", rf_we, 1'b1);
      checkOutput("lb_wdata", rf_wdata, 32'hFFFFFF80);
      checkOutput("lb_ready", in_ready, 1'b1);

      // LHU offset 2, retire overlapped with an ALU rd=x0 transfer
      applyStimulus(1, 2'd1, 1, 5'd4, 3'b101, 32'h2002, 0, 0, 0, 0, 0);
      applyStimulus(1, 2'd0, 1, 5'd0, 3'd0, 32'h55, 0, 0, 1, 32'h80010000, 0);
      checkOutput("lhu_wdata", rf_wdata, 32'h00008001);
      checkOutput("lhu_waddr", rf_waddr, 5'd4);
      idleCycle(0, 0, 0);
      checkOutput("x0_we", rf_we, 1'b0);
      checkOutput("x0_wdata", rf_wdata, 32'h55);

      // Flush an outstanding LW, then drain its response
      applyStimulus(1, 2'd1, 1, 5'd6, 3'b010, 32'h3000, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      idleCycle(0, 0, 1);
      checkOutput("flush_we", rf_we, 1'b0);
      applyStimulus(1, 2'd0, 1, 5'd9, 3'd0, 32'h99, 0, 0, 0, 0, 0);
      checkOutput("drain_ready", in_ready, 1'b0);
      checkOutput("drain_wdata", rf_wdata, 32'd0);
      idleCycle(1, 32'hDEADBEEF, 0);
      checkOutput("drain_rsp_we", rf_we, 1'b0);
      checkOutput("drain_rsp_ready", in_ready, 1'b0);
      idleCycle(0, 0, 0);
      checkOutput("post_drain_ready", in_ready, 1'b1);

      // LH at odd offset 1 uses the low half
      applyStimulus(1, 2'd1, 1, 5'd7, 3'b001, 32'h4001, 0, 0, 0, 0, 0);
      idleCycle(1, 32'h1234F00D, 0);
      checkOutput("lh_we", rf_we, 1'b1);
      checkOutput("lh_wdata", rf_wdata, 32'hFFFFF00D);

      // LBU offset 3 overlapped with LB offset 0, then funct3=011 whole word
      applyStimulus(1, 2'd1, 1, 5'd8, 3'b100, 32'h5003, 0, 0, 0, 0, 0);
      applyStimulus(1, 2'd1, 1, 5'd10, 3'b000, 32'h6000, 0, 0, 1, 32'h9A000000, 0);
      checkOutput("lbu_wdata", rf_wdata, 32'h0000009A);
      idleCycle(1, 32'h0000007F, 0);
      checkOutput("lb0_wdata", rf_wdata, 32'h7F);
      applyStimulus(1, 2'd1, 1, 5'd11, 3'b011, 32'h7001, 0, 0, 0, 0, 0);
      idleCycle(1, 32'hCAFEBABE, 0);
      checkOutput("f3_other_wdata", rf_wdata, 32'hCAFEBABE);

      // Stray response with nothing held
      idleCycle(1, 32'h12345678, 0);
      checkOutput("stray_we", rf_we, 1'b0);
      checkOutput("stray_wdata", rf_wdata, 32'd0);

      // Flush beats a retire and a transfer in the same cycle
      applyStimulus(1, 2'd0, 1, 5'd12, 3'd0, 32'h77, 0, 0, 0, 0, 0);
      applyStimulus(1, 2'd0, 1, 5'd13, 3'd0, 32'h88, 0, 0, 0, 0, 1);
      checkOutput("flush_retire_we", rf_we, 1'b0);
      idleCycle(0, 0, 0);
      checkOutput("flush_xfer_wdata", rf_wdata, 32'd0);
`ifdef WB_INSTRET_EN
      checkOutput("instret_literal", instret, 64'd10);
`endif

      // Non-writing instruction still presents data but no write
      applyStimulus(1, 2'd0, 0, 5'd14, 3'd0, 32'h11, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      checkOutput("nowe_we", rf_we, 1'b0);
      checkOutput("nowe_wdata", rf_wdata, 32'h11);

      // Reset while a load is waiting
      applyStimulus(1, 2'd1, 1, 5'd15, 3'b010, 32'h8000, 0, 0, 0, 0, 0);
      idleCycle(0, 0, 0);
      checkOutput("pre_reset_pending", load_pending, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 0; mem_rsp_valid = 0; flush = 0;
      @(posedge clk);
      #1;
      checkResetState("midwait_reset");
      idleCycle(0, 0, 0);
      idleCycle(0, 0, 0);

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
